// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit:
// funct3 encodings, load marker, FSM states, access-size decode helpers
// and the data-memory request payload.
package mem_lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_GNT,
        ST_WAIT_RSP
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } lsu_size_e;

    // Request payload presented on the data-memory port.
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;

    // Unlisted encodings (011/110/111) fall through to word accesses.
    function automatic lsu_size_e size_of(input logic [2:0] f3);
        lsu_size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            F3_W:        sz = SZ_W;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (size_of(f3))
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU.
// Store side: st_funct3/st_off/st_data -> st_be byte enables and
//             lane-replicated st_wdata.
// Load side:  ld_funct3/ld_off/ld_rdata -> ld_data, the selected
//             byte/half sign- or zero-extended, or the full word.
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [2:0]      st_funct3,
    input  logic [1:0]      st_off,
    input  logic [XLEN-1:0] st_data,
    output logic [BE_W-1:0] st_be,
    output logic [XLEN-1:0] st_wdata,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_off,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store: replicate the datum across lanes so memory only needs be.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (size_of(st_funct3))
            SZ_B: begin
                st_be    = 4'(4'b0001 << st_off);
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                st_be    = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    // Load: pick the addressed lane, then extend; funct3[2] selects unsigned.
    always_comb begin
        byte_sel = 8'(ld_rdata >> {ld_off, 3'b000});
        half_sel = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_data  = ld_rdata;
        case (size_of(ld_funct3))
            SZ_B:    ld_data = ld_funct3[2] ? {24'd0, byte_sel}
                                            : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    ld_data = ld_funct3[2] ? {16'd0, half_sel}
                                            : {{16{half_sel[15]}}, half_sel};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit.
// Inputs : clk, reset (sync, active-high); M-stage funct3M, MemWriteM,
//          ResultSrcM, ALUResultM, WriteDataM; memory dmem_gnt,
//          dmem_rvalid, dmem_rdata.
// Outputs: dmem_req/we/addr/be/wdata request port; ReadDataM load result;
//          StallM pipeline freeze; MisalignM and BusErrM 1-cycle flags.
module mem_stage_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      funct3M,
    input  logic            MemWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [BE_W-1:0] dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] ReadDataM,
    output logic            StallM,
    output logic            MisalignM,
    output logic            BusErrM
);

    lsu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]      off_q;
    logic [2:0]      f3_q;

    logic            cnt_clr, cnt_inc, latch;
    logic            access, misalign, timeout;
    logic [BE_W-1:0] be_al;
    logic [XLEN-1:0] wdata_al, ld_ext;
    dmem_req_t       cur_pl, req_pl;

    // A simultaneous load marker and store is resolved as a store.
    assign access   = MemWriteM || (ResultSrcM == RESULTSRC_LOAD);
    assign misalign = access && is_misaligned(funct3M, ALUResultM[1:0]);
    assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    lsu_align u_align (
        .st_funct3 (funct3M),
        .st_off    (ALUResultM[1:0]),
        .st_data   (WriteDataM),
        .st_be     (be_al),
        .st_wdata  (wdata_al),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .ld_rdata  (dmem_rdata),
        .ld_data   (ld_ext)
    );

    // Payload comes straight from the M-stage inputs, which StallM holds steady.
    always_comb begin
        cur_pl.we    = MemWriteM;
        cur_pl.addr  = {ALUResultM[31:2], 2'b00};
        cur_pl.be    = be_al;
        cur_pl.wdata = wdata_al;
    end

    // State, timeout counter and latched load-extract controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            off_q   <= 2'b00;
            f3_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (latch) begin
                off_q <= ALUResultM[1:0];
                f3_q  <= funct3M;
            end
        end
    end

    // Next state and outputs; everything is forced quiet during reset.
    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        latch     = 1'b0;
        req_pl    = '0;
        dmem_req  = 1'b0;
        ReadDataM = '0;
        StallM    = 1'b0;
        MisalignM = 1'b0;
        BusErrM   = 1'b0;

        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (misalign) begin
                        MisalignM = 1'b1;
                    end else if (access) begin
                        dmem_req = 1'b1;
                        req_pl   = cur_pl;
                        StallM   = 1'b1;
                        latch    = 1'b1;
                        cnt_clr  = 1'b1;
                        state_d  = dmem_gnt ? ST_WAIT_RSP : ST_WAIT_GNT;
                    end
                end
                ST_WAIT_GNT: begin
                    // Abort drops req, so a grant in the timeout cycle is moot.
                    if (timeout) begin
                        BusErrM = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        dmem_req = 1'b1;
                        req_pl   = cur_pl;
                        StallM   = 1'b1;
                        cnt_inc  = 1'b1;
                        if (dmem_gnt) begin
                            cnt_clr = 1'b1;
                            state_d = ST_WAIT_RSP;
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    if (dmem_rvalid) begin
                        ReadDataM = ld_ext;
                        state_d   = ST_IDLE;
                    end else if (timeout) begin
                        BusErrM = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        StallM  = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign dmem_we    = req_pl.we;
    assign dmem_addr  = req_pl.addr;
    assign dmem_be    = req_pl.be;
    assign dmem_wdata = req_pl.wdata;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk;
    logic        reset;
    logic [2:0]  funct3M;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        BusErrM;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk         (clk),
        .reset       (reset),
        .funct3M     (funct3M),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .ReadDataM   (ReadDataM),
        .StallM      (StallM),
        .MisalignM   (MisalignM),
        .BusErrM     (BusErrM)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  f3;
        logic        mw;
        logic [1:0]  rs;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        mis;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdm;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_access(input logic [2:0] f3, input logic mw, input logic [1:0] rs,
                                input logic [31:0] addr, input logic [31:0] wd);
        funct3M    = f3;
        MemWriteM  = mw;
        ResultSrcM = rs;
        ALUResultM = addr;
        WriteDataM = wd;
    endtask

    task automatic drive_none();
        drive_access(3'b000, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, ".req"}, dmem_req, 1'b0);
        chk1({tag, ".stall"}, StallM, 1'b0);
        chk1({tag, ".mis"}, MisalignM, 1'b0);
        chk1({tag, ".buserr"}, BusErrM, 1'b0);
        chk32({tag, ".rdm"}, ReadDataM, 32'h0);
    endtask

    initial begin
        //         f3      mw    rs     addr        wd            rd            mis   we    be      wdata         rdm
        vecs[0]  = '{3'b010, 1'b1, 2'b00, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{3'b000, 1'b1, 2'b00, 32'h203, 32'h000000A5, 32'h0,        1'b0, 1'b1, 4'b1000, 32'hA5A5A5A5, 32'h0};
        vecs[2]  = '{3'b001, 1'b1, 2'b00, 32'h202, 32'h1234BEEF, 32'h0,        1'b0, 1'b1, 4'b1100, 32'hBEEFBEEF, 32'h0};
        vecs[3]  = '{3'b000, 1'b0, 2'b01, 32'h101, 32'h0,        32'h00008000, 1'b0, 1'b0, 4'b0010, 32'h0,        32'hFFFFFF80};
        vecs[4]  = '{3'b100, 1'b0, 2'b01, 32'h101, 32'h0,        32'h00008000, 1'b0, 1'b0, 4'b0010, 32'h0,        32'h00000080};
        vecs[5]  = '{3'b001, 1'b0, 2'b01, 32'h102, 32'h0,        32'h80010000, 1'b0, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001};
        vecs[6]  = '{3'b101, 1'b0, 2'b01, 32'h102, 32'h0,        32'h80010000, 1'b0, 1'b0, 4'b1100, 32'h0,        32'h00008001};
        vecs[7]  = '{3'b010, 1'b0, 2'b01, 32'h104, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 4'b1111, 32'h0,        32'hCAFEF00D};
        vecs[8]  = '{3'b010, 1'b0, 2'b01, 32'h102, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
        vecs[9]  = '{3'b001, 1'b0, 2'b01, 32'h101, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
        vecs[10] = '{3'b011, 1'b0, 2'b01, 32'h108, 32'h0,        32'h11223344, 1'b0, 1'b0, 4'b1111, 32'h0,        32'h11223344};
        vecs[11] = '{3'b010, 1'b1, 2'b01, 32'h10C, 32'h01020304, 32'h0,        1'b0, 1'b1, 4'b1111, 32'h01020304, 32'h0};
        vecs[12] = '{3'b000, 1'b0, 2'b01, 32'h103, 32'h0,        32'h7F000000, 1'b0, 1'b0, 4'b1000, 32'h0,        32'h0000007F};

        reset       = 1'b1;
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;

        // Reset cycle: a valid access must not issue a request.
        drive_access(3'b010, 1'b1, 2'b00, 32'h100, 32'h12345678);
        @(negedge clk);
        chk_quiet("rst_access");
        chk1("rst_access.we", dmem_we, 1'b0);
        next_cycle();
        drive_access(3'b010, 1'b0, 2'b01, 32'h102, 32'h0);
        @(negedge clk);
        chk_quiet("rst_misalign");
        next_cycle();
        reset = 1'b0;
        drive_none();
        dmem_gnt = 1'b0;
        @(negedge clk);
        chk_quiet("post_rst_idle");
        next_cycle();

        // Table: grant in request cycle, response one cycle later, back-to-back.
        for (int i = 0; i < NV; i++) begin
            drive_access(vecs[i].f3, vecs[i].mw, vecs[i].rs, vecs[i].addr, vecs[i].wd);
            dmem_gnt    = 1'b1;
            dmem_rvalid = 1'b0;
            dmem_rdata  = 32'h0;
            @(negedge clk);
            if (vecs[i].mis) begin
                chk1($sformatf("v%0d.mis", i), MisalignM, 1'b1);
                chk1($sformatf("v%0d.req", i), dmem_req, 1'b0);
                chk1($sformatf("v%0d.stall", i), StallM, 1'b0);
                chk32($sformatf("v%0d.rdm", i), ReadDataM, 32'h0);
                next_cycle();
            end else begin
                chk1($sformatf("v%0d.mis", i), MisalignM, 1'b0);
                chk1($sformatf("v%0d.req", i), dmem_req, 1'b1);
                chk1($sformatf("v%0d.we", i), dmem_we, vecs[i].exp_we);
                chk32($sformatf("v%0d.addr", i), dmem_addr, {vecs[i].addr[31:2], 2'b00});
                chk32($sformatf("v%0d.be", i), {28'd0, dmem_be}, {28'd0, vecs[i].exp_be});
                chk32($sformatf("v%0d.wdata", i), dmem_wdata, vecs[i].exp_wdata);
                chk1($sformatf("v%0d.stall_req", i), StallM, 1'b1);
                chk32($sformatf("v%0d.rdm_req", i), ReadDataM, 32'h0);
                next_cycle();
                dmem_gnt    = 1'b0;
                dmem_rvalid = 1'b1;
                dmem_rdata  = vecs[i].rd;
                @(negedge clk);
                chk1($sformatf("v%0d.stall_rsp", i), StallM, 1'b0);
                chk1($sformatf("v%0d.req_rsp", i), dmem_req, 1'b0);
                chk32($sformatf("v%0d.rdm_rsp", i), ReadDataM, vecs[i].exp_rdm);
                next_cycle();
                dmem_rvalid = 1'b0;
                dmem_rdata  = 32'h0;
            end
        end

        // Grant delayed 3 cycles, response 2 cycles after grant.
        drive_access(3'b101, 1'b0, 2'b01, 32'h202, 32'h0);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            dmem_gnt    = (c == 3);
            dmem_rvalid = (c == 5);
            dmem_rdata  = (c >= 4) ? 32'hABCD1234 : 32'h0;
            @(negedge clk);
            chk1($sformatf("dly%0d.req", c), dmem_req, (c <= 3));
            chk1($sformatf("dly%0d.stall", c), StallM, (c <= 4));
            chk32($sformatf("dly%0d.rdm", c), ReadDataM, (c == 5) ? 32'h0000ABCD : 32'h0);
            if (c <= 3) begin
                chk32($sformatf("dly%0d.addr", c), dmem_addr, 32'h200);
                chk32($sformatf("dly%0d.be", c), {28'd0, dmem_be}, 32'h0000000C);
            end
            next_cycle();
        end
        dmem_rvalid = 1'b0;
        dmem_gnt    = 1'b0;
        drive_none();
        @(negedge clk);
        chk_quiet("dly_after");
        next_cycle();

        // Grant never arrives: BusErrM once, on the 64th waiting cycle.
        drive_access(3'b010, 1'b0, 2'b01, 32'h300, 32'h0);
        @(negedge clk);
        chk1("to.req0", dmem_req, 1'b1);
        next_cycle();
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            chk1($sformatf("to%0d.buserr", k), BusErrM, (k == 64));
            chk1($sformatf("to%0d.stall", k), StallM, (k != 64));
            chk1($sformatf("to%0d.req", k), dmem_req, (k != 64));
            next_cycle();
        end
        drive_none();
        @(negedge clk);
        chk_quiet("to_after");
        next_cycle();

        // Reset while waiting for the response; the late rvalid is ignored.
        drive_access(3'b010, 1'b0, 2'b01, 32'h104, 32'h0);
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk1("rr.req", dmem_req, 1'b1);
        next_cycle();
        dmem_gnt = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk_quiet("rr.in_reset");
        next_cycle();
        reset = 1'b0;
        drive_none();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFFFFFF;
        @(negedge clk);
        chk_quiet("rr.stray");
        next_cycle();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;

        // Normal access after the aborted one.
        drive_access(3'b000, 1'b0, 2'b01, 32'h108, 32'h0);
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk1("rr2.req", dmem_req, 1'b1);
        chk32("rr2.addr", dmem_addr, 32'h108);
        next_cycle();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h000000FE;
        @(negedge clk);
        chk32("rr2.rdm", ReadDataM, 32'hFFFFFFFE);
        chk1("rr2.stall", StallM, 1'b0);
        next_cycle();
        dmem_rvalid = 1'b0;
        drive_none();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
